// File: rtl/mem_fetch_unit_pkg.sv
// Shared constants for the memory fetch front end: address source codes,
// FSM state encodings and read target selection.
package mem_fetch_unit_pkg;

   // memAddr source select codes driven by the control unit
   localparam logic [1:0] SRC_PC     = 2'd0;
   localparam logic [1:0] SRC_OPADDR = 2'd1;
   localparam logic [1:0] SRC_REGC   = 2'd2;
   localparam logic [1:0] SRC_RSVD   = 2'd3;

   // Older names still used by the control unit sources
   localparam logic [1:0] READ_FROM_PC     = SRC_PC;
   localparam logic [1:0] READ_FROM_OPADDR = SRC_OPADDR;
   localparam logic [1:0] READ_FROM_REGC   = SRC_REGC;

   // Fetch FSM state encodings
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_ERROR = 2'd2;

   // Destination register of an outstanding read
   typedef enum logic {
      TGT_OPCODE = 1'b0,
      TGT_MEM    = 1'b1
   } target_e;

   // A reserved source code never produces a bus request
   function automatic logic src_is_valid(input logic [1:0] src);
      return src != SRC_RSVD;
   endfunction

endpackage

// File: rtl/mem_fetch_unit_if.sv
// Read-only memory bus between the fetch unit (master) and memory (slave).
interface mem_fetch_unit_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic [ADDR_W-1:0] busAddr;
   logic              busReq;
   logic              busAck;
   logic [DATA_W-1:0] busRdata;

   modport master (
      output busAddr,
      output busReq,
      input  busAck,
      input  busRdata
   );

   modport slave (
      input  busAddr,
      input  busReq,
      output busAck,
      output busRdata
   );
endinterface

// File: rtl/mem_fetch_unit_timeout.sv
// Wait-cycle counter for the fetch FSM: cleared when a request is issued,
// incremented on every unacknowledged WAIT cycle, flags the last allowed cycle.
module mem_timeout_counter #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic inc_i,
   output logic term_o
);

   logic [7:0] cnt_q;
   logic [7:0] cnt_d;

   // Next count: clear wins over increment
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = 8'd0;
      end else if (inc_i) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   // Count register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign term_o = (cnt_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mem_fetch_unit.sv
// Memory-read front end of the CPU control unit. Converts saveOpcode/saveMem
// strobes into a req/ack read on the memory bus, owns the opcode and memValue
// registers and stalls the control FSM until read data is captured.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no read outstanding; strobes accepted
// ST_WAIT  | busReq high, address held, waiting for busAck
// ST_ERROR | timeout or reserved source seen; stalled until rst
module mem_fetch_unit
   import mem_fetch_unit_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 16,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        memAddr,
   input  logic              saveOpcode,
   input  logic              saveMem,
   input  logic [ADDR_W-1:0] pc,
   input  logic [ADDR_W-1:0] opAddr,
   input  logic [ADDR_W-1:0] regC,
   mem_fetch_unit_if.master  bus,
   output logic [DATA_W-1:0] opcode,
   output logic [DATA_W-1:0] memValue,
   output logic              stall,
   output logic              busError
);

   logic [1:0]        state_q,    state_d;
   logic              busReq_q,   busReq_d;
   logic [ADDR_W-1:0] busAddr_q,  busAddr_d;
   logic [DATA_W-1:0] opcode_q,   opcode_d;
   logic [DATA_W-1:0] memValue_q, memValue_d;
   logic              busError_q, busError_d;
   target_e           tgt_q,      tgt_d;

   logic              start;
   logic [ADDR_W-1:0] addr_sel;
   logic              cnt_clr;
   logic              cnt_inc;
   logic              cnt_term;

   assign start = (state_q == ST_IDLE) && (saveOpcode || saveMem);

   // Address source mux; the reserved code never reaches the bus
   always_comb begin
      addr_sel = '0;
      case (memAddr)
         SRC_PC:     addr_sel = pc;
         SRC_OPADDR: addr_sel = opAddr;
         SRC_REGC:   addr_sel = regC;
         default:    addr_sel = '0;
      endcase
   end

   mem_timeout_counter #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (cnt_clr),
      .inc_i  (cnt_inc),
      .term_o (cnt_term)
   );

   // Fetch FSM next-state and register updates
   always_comb begin
      state_d    = state_q;
      busReq_d   = busReq_q;
      busAddr_d  = busAddr_q;
      opcode_d   = opcode_q;
      memValue_d = memValue_q;
      busError_d = busError_q;
      tgt_d      = tgt_q;
      cnt_clr    = 1'b0;
      cnt_inc    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (src_is_valid(memAddr)) begin
                  busAddr_d = addr_sel;
                  tgt_d     = saveOpcode ? TGT_OPCODE : TGT_MEM;
                  busReq_d  = 1'b1;
                  cnt_clr   = 1'b1;
                  state_d   = ST_WAIT;
               end else begin
                  busError_d = 1'b1;
                  state_d    = ST_ERROR;
               end
            end
         end
         ST_WAIT: begin
            if (bus.busAck) begin
               if (tgt_q == TGT_OPCODE) begin
                  opcode_d = bus.busRdata;
               end else begin
                  memValue_d = bus.busRdata;
               end
               busReq_d = 1'b0;
               state_d  = ST_IDLE;
            end else if (cnt_term) begin
               busReq_d   = 1'b0;
               busError_d = 1'b1;
               state_d    = ST_ERROR;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         ST_ERROR: begin
            busReq_d = 1'b0;
         end
         default: begin
            busReq_d = 1'b0;
            state_d  = ST_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         busReq_q   <= 1'b0;
         busAddr_q  <= '0;
         opcode_q   <= '0;
         memValue_q <= '0;
         busError_q <= 1'b0;
         tgt_q      <= TGT_OPCODE;
      end else begin
         state_q    <= state_d;
         busReq_q   <= busReq_d;
         busAddr_q  <= busAddr_d;
         opcode_q   <= opcode_d;
         memValue_q <= memValue_d;
         busError_q <= busError_d;
         tgt_q      <= tgt_d;
      end
   end

   // Stall covers the strobe cycle, every unacknowledged wait and the error state
   always_comb begin
      stall = start
           || ((state_q == ST_WAIT) && !bus.busAck)
           || (state_q == ST_ERROR);
   end

   assign bus.busReq  = busReq_q;
   assign bus.busAddr = busAddr_q;
   assign opcode      = opcode_q;
   assign memValue    = memValue_q;
   assign busError    = busError_q;

endmodule

// File: tb/tb_mem_fetch_unit.sv
// Bench for mem_fetch_unit: directed scenarios followed by randomized traffic,
// all outputs compared every cycle against a transaction-level model.
module tb_mem_fetch_unit;
   import mem_fetch_unit_pkg::*;

   localparam int DW = 16;
   localparam int AW = 16;
   localparam int TO = 15;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    memAddr;
   logic          saveOpcode;
   logic          saveMem;
   logic [AW-1:0] pc;
   logic [AW-1:0] opAddr;
   logic [AW-1:0] regC;
   logic [DW-1:0] opcode;
   logic [DW-1:0] memValue;
   logic          stall;
   logic          busError;

   always #5 clk = ~clk;

   mem_fetch_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

   mem_fetch_unit #(
      .DATA_W  (DW),
      .ADDR_W  (AW),
      .TIMEOUT (TO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .memAddr    (memAddr),
      .saveOpcode (saveOpcode),
      .saveMem    (saveMem),
      .pc         (pc),
      .opAddr     (opAddr),
      .regC       (regC),
      .bus        (bus_if),
      .opcode     (opcode),
      .memValue   (memValue),
      .stall      (stall),
      .busError   (busError)
   );

   int n_checks = 0;
   int n_errors = 0;
   int stall_cnt = 0;
   int req_cnt = 0;

   // Reference model: one outstanding read, how long it has waited, sticky error
   bit          m_busy;
   bit          m_err;
   bit          m_to_op;
   int          m_waited;
   logic [15:0] m_addr;
   logic [15:0] m_op;
   logic [15:0] m_mem;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_err = 0; m_to_op = 0; m_waited = 0;
      m_addr = '0; m_op = '0; m_mem = '0;
   endtask

   task automatic model_edge();
      if (rst) begin
         model_reset();
      end else if (m_err) begin
         // terminal until reset
      end else if (m_busy) begin
         if (bus_if.busAck) begin
            if (m_to_op) m_op = bus_if.busRdata;
            else         m_mem = bus_if.busRdata;
            m_busy = 0;
         end else if (m_waited == TO - 1) begin
            m_busy = 0;
            m_err  = 1;
         end else begin
            m_waited++;
         end
      end else if (saveOpcode || saveMem) begin
         if (memAddr == 2'd3) begin
            m_err = 1;
         end else begin
            m_busy   = 1;
            m_waited = 0;
            m_to_op  = saveOpcode;
            m_addr   = (memAddr == 2'd0) ? pc : (memAddr == 2'd1) ? opAddr : regC;
         end
      end
   endtask

   // One clock: compare at negedge, advance model at posedge, release inputs after
   task automatic cyc();
      bit exp_stall;
      @(negedge clk);
      exp_stall = m_err || (m_busy && !bus_if.busAck)
               || (!m_busy && !m_err && (saveOpcode || saveMem));
      chk("busReq",   32'(bus_if.busReq),  32'(m_busy));
      chk("busAddr",  32'(bus_if.busAddr), 32'(m_addr));
      chk("opcode",   32'(opcode),         32'(m_op));
      chk("memValue", 32'(memValue),       32'(m_mem));
      chk("busError", 32'(busError),       32'(m_err));
      chk("stall",    32'(stall),          32'(exp_stall));
      if (stall) stall_cnt++;
      if (bus_if.busReq) req_cnt++;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle_inputs();
      rst = 0; saveOpcode = 0; saveMem = 0;
      bus_if.busAck = 0; bus_if.busRdata = '0;
   endtask

   initial begin
      rst = 1; memAddr = SRC_PC; saveOpcode = 0; saveMem = 0;
      pc = '0; opAddr = '0; regC = '0;
      bus_if.busAck = 0; bus_if.busRdata = '0;
      model_reset();
      @(posedge clk); #1;
      @(posedge clk); #1;
      idle_inputs();
      cyc();
      chk("reset_opcode", 32'(opcode), 32'h0);
      chk("reset_busReq", 32'(bus_if.busReq), 32'h0);

      // opcode fetch from pc, ack in first wait cycle
      stall_cnt = 0; req_cnt = 0;
      saveOpcode = 1; memAddr = SRC_PC; pc = 16'h0040;
      cyc();
      bus_if.busAck = 1; bus_if.busRdata = 16'h1234;
      chk("s1_busAddr", 32'(bus_if.busAddr), 32'h0040);
      cyc();
      idle_inputs();
      cyc();
      chk("s1_opcode", 32'(opcode), 32'h1234);
      chk("s1_memValue", 32'(memValue), 32'h0);
      chk("s1_stall_cycles", 32'(stall_cnt), 32'd1);
      chk("s1_req_cycles", 32'(req_cnt), 32'd1);

      // memValue read through regC, ack after three wait cycles
      stall_cnt = 0;
      saveMem = 1; memAddr = SRC_REGC; regC = 16'h0100;
      cyc();
      for (int i = 0; i < 3; i++) cyc();
      bus_if.busAck = 1; bus_if.busRdata = 16'hBEEF;
      cyc();
      idle_inputs();
      cyc();
      chk("s2_memValue", 32'(memValue), 32'hBEEF);
      chk("s2_opcode", 32'(opcode), 32'h1234);
      chk("s2_stall_cycles", 32'(stall_cnt), 32'd4);

      // both strobes: opcode wins
      saveOpcode = 1; saveMem = 1; memAddr = SRC_OPADDR; opAddr = 16'h0200;
      cyc();
      bus_if.busAck = 1; bus_if.busRdata = 16'h5555;
      cyc();
      idle_inputs();
      cyc();
      chk("s3_opcode", 32'(opcode), 32'h5555);
      chk("s3_memValue", 32'(memValue), 32'hBEEF);
      chk("s3_busAddr", 32'(bus_if.busAddr), 32'h0200);

      // timeout: no ack for TIMEOUT wait cycles
      req_cnt = 0;
      saveOpcode = 1; memAddr = SRC_PC; pc = 16'h0300;
      cyc();
      for (int i = 0; i < TO; i++) cyc();
      chk("s4_req_cycles", 32'(req_cnt), 32'(TO));
      chk("s4_busError", 32'(busError), 32'h1);
      for (int i = 0; i < 5; i++) begin
         saveMem = 1; bus_if.busAck = 1; bus_if.busRdata = 16'hAAAA;
         cyc();
      end
      chk("s4_stall_held", 32'(stall), 32'h1);
      chk("s4_opcode_kept", 32'(opcode), 32'h5555);
      idle_inputs(); rst = 1;
      cyc();
      idle_inputs();
      cyc();
      chk("s4_rst_busError", 32'(busError), 32'h0);
      chk("s4_rst_opcode", 32'(opcode), 32'h0);
      chk("s4_rst_memValue", 32'(memValue), 32'h0);

      // reserved source
      req_cnt = 0;
      saveMem = 1; memAddr = SRC_RSVD;
      cyc();
      chk("s5_busError", 32'(busError), 32'h1);
      for (int i = 0; i < 3; i++) cyc();
      chk("s5_req_cycles", 32'(req_cnt), 32'd0);
      idle_inputs(); rst = 1;
      cyc();
      idle_inputs();

      // reset in the second wait cycle, late ack afterwards
      saveOpcode = 1; memAddr = SRC_PC; pc = 16'h0400;
      cyc();
      cyc();
      idle_inputs(); rst = 1;
      cyc();
      idle_inputs(); bus_if.busAck = 1; bus_if.busRdata = 16'hFFFF;
      cyc();
      idle_inputs();
      cyc();
      chk("s6_busReq", 32'(bus_if.busReq), 32'h0);
      chk("s6_opcode", 32'(opcode), 32'h0);
      chk("s6_memValue", 32'(memValue), 32'h0);
      chk("s6_stall", 32'(stall), 32'h0);

      // randomized traffic; later blocks make acks scarce to reach timeouts
      for (int i = 0; i < 3000; i++) begin
         int ack_mod;
         ack_mod = ((i / 500) % 2 == 0) ? 3 : 19;
         rst        = ($urandom_range(0, 59) == 0);
         saveOpcode = ($urandom_range(0, 2) == 0);
         saveMem    = ($urandom_range(0, 2) == 0);
         memAddr    = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         pc         = 16'($urandom);
         opAddr     = 16'($urandom);
         regC       = 16'($urandom);
         bus_if.busAck   = ($urandom_range(0, ack_mod - 1) == 0);
         bus_if.busRdata = 16'($urandom);
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
